sevenseg_scan: RTL

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

---
 rtl/sevenseg_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: eight-digit multiplexed seven-segment scanner.
// A free-running prescaler steps the digit index. HEX and DP_IN are captured
// into shadow registers at every frame boundary, so one scan never mixes two
// values. ANODE, CATHODE and DP are registered and active-low.
// Optional feature: define SEVENSEG_LZB_EN to blank leading zero digits.
module sevenseg_scan #(
  parameter int PRESCALE_W = 17
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] HEX,
  input  logic [7:0]  DP_IN,
  input  logic        ENABLE,
  output logic [7:0]  ANODE,
  output logic [6:0]  CATHODE,
  output logic        DP,
  output logic        FRAME
);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           shadow_hex_q, shadow_hex_d;
  logic [7:0]            shadow_dp_q, shadow_dp_d;
  logic                  load_pending_q, load_pending_d;
  logic                  frame_q, frame_d;
  logic [7:0]            anode_q, anode_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  dp_q, dp_d;

  logic                  tick;
  logic                  load;
  logic [3:0]            nibble;
  logic                  blank_digit;

  // Segment patterns, active-low, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick   = &prescale_q;
  // A pending post-reset load and a frame-boundary load merge into one load.
  assign load   = load_pending_q | (tick & (idx_q == 3'd7));
  assign nibble = shadow_hex_q[{idx_q, 2'b00} +: 4];

`ifdef SEVENSEG_LZB_EN
  // lead_zero[d]: every shadow nibble from d up to 7 is zero.
  logic [7:0] lead_zero;
  for (genvar gi = 0; gi < 8; gi++) begin : g_lead_zero
    assign lead_zero[gi] = (shadow_hex_q[31:4*gi] == '0);
  end
  // Digit 0 always shows; a requested decimal point keeps a digit lit.
  assign blank_digit = (idx_q != 3'd0) & lead_zero[idx_q] & ~shadow_dp_q[idx_q];
`else
  assign blank_digit = 1'b0;
`endif

  // Scan timing, shadow capture and frame pulse.
  always_comb begin
    prescale_d     = prescale_q + PRESCALE_W'(1);
    idx_d          = tick ? idx_q + 3'd1 : idx_q;
    shadow_hex_d   = shadow_hex_q;
    shadow_dp_d    = shadow_dp_q;
    load_pending_d = 1'b0;
    frame_d        = load;
    if (load) begin
      shadow_hex_d = HEX;
      shadow_dp_d  = DP_IN;
    end
  end

  // Output decode for the current digit; everything dark when disabled or blanked.
  always_comb begin
    anode_d   = 8'hFF;
    cathode_d = 7'h7F;
    dp_d      = 1'b1;
    if (ENABLE && !blank_digit) begin
      anode_d[idx_q] = 1'b0;
      cathode_d      = seg(nibble);
      dp_d           = ~shadow_dp_q[idx_q];
    end
  end

  // State and output registers; reset aborts the scan and arms the first load.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      prescale_q     <= '0;
      idx_q          <= 3'd0;
      shadow_hex_q   <= 32'h0;
      shadow_dp_q    <= 8'h00;
      load_pending_q <= 1'b1;
      frame_q        <= 1'b0;
      anode_q        <= 8'hFF;
      cathode_q      <= 7'h7F;
      dp_q           <= 1'b1;
    end else begin
      prescale_q     <= prescale_d;
      idx_q          <= idx_d;
      shadow_hex_q   <= shadow_hex_d;
      shadow_dp_q    <= shadow_dp_d;
      load_pending_q <= load_pending_d;
      frame_q        <= frame_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      dp_q           <= dp_d;
    end
  end

  assign ANODE   = anode_q;
  assign CATHODE = cathode_q;
  assign DP      = dp_q;
  assign FRAME   = frame_q;

endmodule
